// File: rtl/katadc_serial_config_ctrl_if.sv
// Request/status bundle between the OPB register block, the auto calibration
// engine and the ADC serial configuration sequencer.
interface katadc_serial_config_ctrl_if;
  logic        host_start;
  logic [3:0]  host_addr;
  logic [15:0] host_data;
  logic        host_idle;
  logic        host_overrun;
  logic        auto_start;
  logic [3:0]  auto_addr;
  logic [15:0] auto_data;
  logic        auto_busy;

  modport master (
    output host_start, host_addr, host_data,
    output auto_start, auto_addr, auto_data,
    input  host_idle, host_overrun, auto_busy
  );

  modport slave (
    input  host_start, host_addr, host_data,
    input  auto_start, auto_addr, auto_data,
    output host_idle, host_overrun, auto_busy
  );
endinterface

// File: rtl/katadc_serial_config_ctrl.sv
// ADC 3-wire configuration port sequencer: arbitrates host/auto write requests
// and shifts each {addr,data} frame out MSB first on sclk/sdata/sen_n.
module katadc_serial_config_ctrl #(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = 20
) (
  input  logic                        OPB_Clk,
  input  logic                        OPB_Rst,
  katadc_serial_config_ctrl_if.slave  cfg,
  output logic                        adc_sclk,
  output logic                        adc_sdata,
  output logic                        adc_sen_n
);

  localparam int DIV_W = 8;
  localparam int BIT_W = $clog2(FRAME_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_HOST,
    OWN_AUTO
  } owner_t;

  state_t                state_q, state_d;
  owner_t                owner_q, owner_d;
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic                  phase_q, phase_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [FRAME_BITS-1:0] host_slot_q, auto_slot_q;
  logic                  host_vld_q, host_vld_d;
  logic                  auto_vld_q, auto_vld_d;
  logic                  overrun_q, overrun_d;
  logic                  host_idle_q, auto_busy_q;
  logic                  sclk_q, sdata_q, sen_n_q;
  logic                  host_cap, auto_cap;
  logic                  grant_host, grant_auto;
  logic                  unit_end;

  // A start only lands in an empty slot; a full slot drops the request.
  assign host_cap = cfg.host_start & ~host_vld_q;
  assign auto_cap = cfg.auto_start & ~auto_vld_q;
  assign unit_end = (div_cnt_q == DIV_LAST);

  always_comb begin : fsm_next
    state_d    = state_q;
    owner_d    = owner_q;
    div_cnt_d  = div_cnt_q;
    phase_d    = phase_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    grant_host = 1'b0;
    grant_auto = 1'b0;

    case (state_q)
      ST_IDLE: begin
        div_cnt_d = '0;
        phase_d   = 1'b0;
        bit_cnt_d = '0;
        owner_d   = OWN_NONE;
        if (host_vld_q) begin
          grant_host = 1'b1;
          state_d    = ST_SETUP;
          shreg_d    = host_slot_q;
          owner_d    = OWN_HOST;
        end else if (auto_vld_q) begin
          grant_auto = 1'b1;
          state_d    = ST_SETUP;
          shreg_d    = auto_slot_q;
          owner_d    = OWN_AUTO;
        end
      end
      ST_SETUP: begin
        if (unit_end) begin
          div_cnt_d = '0;
          state_d   = ST_SHIFT;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (unit_end) begin
          div_cnt_d = '0;
          phase_d   = ~phase_q;
          // Data advances as sclk falls, so the ADC sees it stable for a full low phase.
          if (phase_q) begin
            shreg_d   = {shreg_q[FRAME_BITS-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BIT_LAST) begin
              state_d = ST_HOLD;
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (unit_end) begin
          div_cnt_d = '0;
          state_d   = ST_GAP;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (unit_end) begin
          div_cnt_d = '0;
          state_d   = ST_IDLE;
          owner_d   = OWN_NONE;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
    endcase

    host_vld_d = (host_vld_q & ~grant_host) | host_cap;
    auto_vld_d = (auto_vld_q & ~grant_auto) | auto_cap;
    overrun_d  = overrun_q | (cfg.host_start & host_vld_q);
  end

  // Control state and pin drivers; pins are registered from next-state so they never glitch.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_NONE;
      div_cnt_q   <= '0;
      phase_q     <= 1'b0;
      bit_cnt_q   <= '0;
      host_vld_q  <= 1'b0;
      auto_vld_q  <= 1'b0;
      overrun_q   <= 1'b0;
      host_idle_q <= 1'b1;
      auto_busy_q <= 1'b0;
      sclk_q      <= 1'b0;
      sdata_q     <= 1'b0;
      sen_n_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      div_cnt_q   <= div_cnt_d;
      phase_q     <= phase_d;
      bit_cnt_q   <= bit_cnt_d;
      host_vld_q  <= host_vld_d;
      auto_vld_q  <= auto_vld_d;
      overrun_q   <= overrun_d;
      host_idle_q <= ~(host_vld_d | (owner_d == OWN_HOST));
      auto_busy_q <= auto_vld_d | (owner_d == OWN_AUTO);
      sclk_q      <= (state_d == ST_SHIFT) & phase_d;
      sdata_q     <= ((state_d == ST_SETUP) | (state_d == ST_SHIFT)) & shreg_d[FRAME_BITS-1];
      sen_n_q     <= ~((state_d == ST_SETUP) | (state_d == ST_SHIFT) | (state_d == ST_HOLD));
    end
  end

  always_ff @(posedge OPB_Clk) begin
    shreg_q <= shreg_d;
    if (host_cap) begin
      host_slot_q <= {cfg.host_addr, cfg.host_data};
    end
    if (auto_cap) begin
      auto_slot_q <= {cfg.auto_addr, cfg.auto_data};
    end
  end

  assign cfg.host_idle    = host_idle_q;
  assign cfg.auto_busy    = auto_busy_q;
  assign cfg.host_overrun = overrun_q;
  assign adc_sclk         = sclk_q;
  assign adc_sdata        = sdata_q;
  assign adc_sen_n        = sen_n_q;

endmodule

// File: doc/katadc_serial_config_ctrl.md
Name: katadc_serial_config_ctrl

Overview:
- Sequences the ADC 3-wire serial configuration port.
- Arbitrates write requests from two requesters:
  - host: the OPB register interface, driving config_data/addr/start and reading config_idle;
  - auto: the automatic calibration/init engine, which reads auto_busy.
- Serialises each 20-bit frame (4-bit address, then 16-bit data, MSB first) onto sclk/sdata/sen_n.
- One instance per ADC, in the OPB clock domain beside the OPB attach block.

Parameters:
- CLK_DIV, 4, OPB_Clk cycles per sclk half-period; legal range 1..255.
- FRAME_BITS, 20, bits per frame; fixed at 20, address bits first.

Ports:
- OPB_Clk  in  1  system clock; all logic on the rising edge.
- OPB_Rst  in  1  reset, synchronous, active-high.
- host_start  in  1  one-cycle write request from the OPB register interface.
- host_addr  in  4  register address; sampled when host_start=1.
- host_data  in  16  register data; sampled when host_start=1.
- host_idle  out  1  high when no host request is pending or in flight.
- auto_start  in  1  one-cycle write request from the auto engine.
- auto_addr  in  4  sampled when auto_start=1.
- auto_data  in  16  sampled when auto_start=1.
- auto_busy  out  1  high while an auto request is pending or in flight.
- host_overrun  out  1  sticky; set when host_start arrives while a host request is already pending.
- adc_sclk  out  1  serial clock; idles low.
- adc_sdata  out  1  serial data; changes while sclk is low.
- adc_sen_n  out  1  serial enable, active-low.

Behaviour:

Reset (OPB_Rst=1 on an edge):
- Next cycle: state=IDLE, both pending flags cleared, host_overrun=0.
- Outputs: host_idle=1, auto_busy=0, adc_sclk=0, adc_sdata=0, adc_sen_n=1.
- Reset mid-frame aborts the frame with no further sclk edges.

Request capture:
- Each requester has a one-deep pending slot; {addr,data} are captured on the start cycle.
- A start while that requester's frame is in flight and its slot is empty fills the slot (back-to-back operation).
- host_start while the host slot is already full: request dropped, host_overrun<=1.
- auto_start while the auto slot is full: dropped silently.

Grant:
- Grant happens only in IDLE.
- Fixed priority: host over auto.
- Grant occurs on the cycle after a slot becomes valid. A start arriving in IDLE therefore enters SETUP 1 cycle later.
- Simultaneous host_start and auto_start in IDLE: host frame first; auto waits in its slot and is granted on the IDLE cycle after the host GAP.
- On grant: slot cleared, shift register <= {addr,data}, in-flight owner recorded.

FSM (every state except IDLE lasts in units of CLK_DIV cycles, counted by div_cnt):
- IDLE: sen_n=1, sclk=0.
- SETUP: 1 unit; sen_n=0, sclk=0, sdata=frame bit 19.
- SHIFT: 20 bits × 2 units.
  - Phase 0: sclk=0, sdata=current MSB.
  - Phase 1: sclk=1.
  - At the end of phase 1: shift left; bit_cnt increments.
  - After bit_cnt reaches 19 and its phase 1 ends: go to HOLD.
- HOLD: 1 unit; sclk=0, sen_n=0.
- GAP: 1 unit; sen_n=1, sdata=0; then IDLE.

Timing:
- sen_n is low for 42*CLK_DIV cycles.
- Grant-to-IDLE is 43*CLK_DIV cycles.
- Exactly 20 rising sclk edges per frame.

Status outputs (all registered):
- host_idle = !(host slot valid || owner==host in flight).
- auto_busy = auto slot valid || owner==auto in flight.
- host_idle falls on the cycle after host_start and rises on the cycle after GAP ends.

Test Plan:
- CLK_DIV=2; host_start with addr=4'hA, data=16'h1234 → sen_n low for 84 cycles; 20 sclk rises; bits sampled on rising edges = 20'hA1234; host_idle low from cycle+1 through GAP end.
- Simultaneous host_start (3/16'h00FF) and auto_start (5/16'hFF00) in IDLE → frame 20'h300FF, then 20'h5FF00; auto_busy stays high until the second GAP ends.
- host_start during a host frame, then a third host_start before grant → second frame sent back-to-back; third dropped; host_overrun=1 until OPB_Rst.
- OPB_Rst asserted at bit 7 of a frame → next cycle sen_n=1, sclk=0, sdata=0, host_idle=1, auto_busy=0; no further sclk edges; a new host_start afterwards sends a complete frame.
- CLK_DIV=1; auto_start with 0/16'hFFFF → sclk toggles every cycle; sen_n low for 42 cycles; auto_busy low 43 cycles after grant.
